// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder,
// one quotient bit per clock, with divide-by-zero and quotient-overflow detection.
module seq_divider #(
  parameter int parallelism = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2*parallelism-1:0]   dividend,
  input  logic [parallelism-1:0]     divisor,
  output logic                       busy,
  output logic                       done,
  output logic [parallelism-1:0]     quotient,
  output logic [parallelism-1:0]     remainder,
  output logic                       div_by_zero,
  output logic                       overflow
);

  localparam int N  = parallelism;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [N-1:0]    rem_q;
  logic [N-1:0]    shf_q;
  logic [N-1:0]    dvs_q;
  logic [CW-1:0]   cnt_q;

  logic [N:0]      trial;
  logic            take;
  logic [N-1:0]    rem_d;
  logic [N-1:0]    shf_d;

  // The partial remainder is always below the divisor, so N bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    trial = {rem_q, shf_q[N-1]};
    take  = (trial >= {1'b0, dvs_q});
    rem_d = take ? N'(trial - {1'b0, dvs_q}) : trial[N-1:0];
    shf_d = {shf_q[N-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      shf_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            dvs_q <= divisor;
            busy  <= 1'b1;
            if (divisor == '0) begin
              state_q     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
            end else if (dividend[2*N-1:N] >= divisor) begin
              state_q     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              state_q <= RUN;
              rem_q   <= dividend[2*N-1:N];
              shf_q   <= dividend[N-1:0];
              cnt_q   <= CW'(N);
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          shf_q <= shf_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            done        <= 1'b1;
            quotient    <= shf_d;
            remainder   <= rem_d;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at N=8 and N=16: directed cases, ignored starts, async abort,
// and a random sweep checked against plain integer division.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s8, busy8, done8, z8, o8;
  logic [15:0] dd8;
  logic [7:0]  dv8, q8, r8;
  logic        s16, busy16, done16, z16, o16;
  logic [31:0] dd16;
  logic [15:0] dv16, q16, r16;

  seq_divider #(.parallelism(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .dividend(dd8), .divisor(dv8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(z8), .overflow(o8));

  seq_divider #(.parallelism(16)) u_div16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .dividend(dd16), .divisor(dv16),
    .busy(busy16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(z16), .overflow(o16));

  int checks = 0;
  int errors = 0;
  int sel_v  = 0;

  logic        cb, cd, cz, co;
  logic [15:0] cq, cr;
  logic [33:0] prev_out;

  always_comb begin
    if (sel_v == 0) begin
      cb = busy8;  cd = done8;  cz = z8;  co = o8;
      cq = {8'h00, q8}; cr = {8'h00, r8};
    end else begin
      cb = busy16; cd = done16; cz = z16; co = o16;
      cq = q16; cr = r16;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned integer division with the error rules applied on top.
  function automatic void model(input int w, input logic [31:0] dd, input logic [15:0] dv,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic z, output logic o);
    longint unsigned ones, quo;
    ones = (64'd1 << w) - 64'd1;
    z = 1'b0; o = 1'b0;
    if (dv == 16'd0) begin
      z = 1'b1; q = 16'(ones); r = 16'(64'(dd) & ones);
    end else begin
      quo = 64'(dd) / 64'(dv);
      if (quo > ones) begin
        o = 1'b1; q = 16'(ones); r = 16'd0;
      end else begin
        q = 16'(quo); r = 16'(64'(dd) % 64'(dv));
      end
    end
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [31:0] dd, input logic [15:0] dv);
    if (sel == 0) begin s8 = v; dd8 = dd[15:0]; dv8 = dv[7:0]; end
    else begin s16 = v; dd16 = dd; dv16 = dv; end
  endtask

  task automatic issue(input int sel, input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    sel_v = sel;
    set_start(sel, 1'b1, dd, dv);
    #1 prev_out = {cq, cr, cz, co};
    @(posedge clk); #1;
    set_start(sel, 1'b0, $urandom, 16'($urandom));
  endtask

  task automatic finish_op(input int sel, input int w, input logic [31:0] dd,
                           input logic [15:0] dv, input bit glitch);
    logic [15:0] eq, er;
    logic        ez, eo;
    int          edges, exp_lat;
    logic [33:0] res;
    model(w, dd, dv, eq, er, ez, eo);
    exp_lat = (ez || eo) ? 0 : w;
    edges = 0;
    while (!cd && edges < 3 * w + 8) begin
      chk("busy_run", 64'(cb), 64'd1);
      chk("hold_out", 64'({cq, cr, cz, co}), 64'(prev_out));
      if (glitch) set_start(sel, edges == 3, 32'h0000_03E8, 16'h0007);
      @(posedge clk); #1;
      edges++;
    end
    if (glitch) set_start(sel, 1'b1, 32'h0000_03E8, 16'h0007);
    chk("done_seen", 64'(cd), 64'd1);
    chk("latency", 64'(edges), 64'(exp_lat));
    chk("busy_done", 64'(cb), 64'd1);
    chk("quotient", 64'(cq), 64'(eq));
    chk("remainder", 64'(cr), 64'(er));
    chk("div_by_zero", 64'(cz), 64'(ez));
    chk("overflow", 64'(co), 64'(eo));
    if (!ez && !eo) begin
      chk("invariant", 64'(cq) * 64'(dv) + 64'(cr), 64'(dd));
      chk("rem_lt_div", 64'(cr < dv), 64'd1);
    end
    res = {cq, cr, cz, co};
    @(posedge clk); #1;
    if (glitch) set_start(sel, 1'b0, 32'd0, 16'd0);
    chk("done_pulse", 64'(cd), 64'd0);
    chk("busy_idle", 64'(cb), 64'd0);
    chk("hold_after", 64'({cq, cr, cz, co}), 64'(res));
  endtask

  task automatic run_op(input int sel, input int w, input logic [31:0] dd,
                        input logic [15:0] dv, input bit glitch);
    issue(sel, dd, dv);
    finish_op(sel, w, dd, dv, glitch);
  endtask

  initial begin
    logic [31:0] dd;
    logic [15:0] dv, hi;
    s8 = 0; dd8 = 0; dv8 = 0; s16 = 0; dd16 = 0; dv16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_out8", 64'({busy8, done8, q8, r8, z8, o8}), 64'd0);
    chk("rst_out16", 64'({busy16, done16, q16, r16, z16, o16}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(0, 8, 32'h0121, 16'h11, 0);
    chk("plan_289_q", 64'(cq), 64'h11);
    run_op(0, 8, 32'h03E8, 16'h07, 0);
    chk("plan_1000_q", 64'(cq), 64'h8E);
    chk("plan_1000_r", 64'(cr), 64'h06);
    run_op(0, 8, 32'hFE01, 16'hFF, 0);
    run_op(0, 8, 32'h1234, 16'h00, 0);
    chk("plan_dbz_r", 64'(cr), 64'h34);
    run_op(0, 8, 32'h1234, 16'h12, 0);
    chk("plan_ovf", 64'({cz, co}), 64'b01);
    run_op(1, 16, 32'h1234_5678, 16'h0000, 0);
    run_op(1, 16, 32'hFFFE_0001, 16'hFFFF, 0);

    // Starts during RUN and DONE are ignored; the next IDLE cycle accepts.
    run_op(0, 8, 32'h0121, 16'h11, 1);
    chk("glitch_q", 64'(cq), 64'h11);
    run_op(0, 8, 32'h03E8, 16'h07, 0);
    chk("b2b_q", 64'(cq), 64'h8E);

    // Asynchronous abort in the middle of an operation.
    issue(0, 32'h0121, 16'h11);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk("abort_out", 64'({busy8, done8, q8, r8, z8, o8}), 64'd0);
    repeat (3) begin @(posedge clk); #1; chk("abort_nodone", 64'(done8), 64'd0); end
    @(negedge clk); rst_n = 1'b1;
    run_op(0, 8, 32'h03E8, 16'h07, 0);

    for (int i = 0; i < 800; i++) begin
      dv = 16'($urandom_range(1, 255));
      hi = 16'($urandom % dv);
      dd = {16'd0, hi[7:0], 8'($urandom)};
      run_op(0, 8, dd, dv, 0);
    end
    for (int i = 0; i < 500; i++) begin
      dv = 16'($urandom_range(1, 65535));
      hi = 16'($urandom % dv);
      dd = {hi, 16'($urandom)};
      run_op(1, 16, dd, dv, 0);
    end
    for (int i = 0; i < 20; i++) begin
      dv = 16'($urandom_range(0, 15));
      dd = {8'd0, 8'($urandom_range(16, 255)), 16'($urandom)};
      run_op(i % 2, (i % 2 == 0) ? 8 : 16, (i % 2 == 0) ? {16'd0, dd[15:0]} : dd, dv, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
